// File: rtl/crt_decrypt_if.sv
// Bus between the CRT decrypt engine and its requester: operands in, plaintext and status out.
interface crt_decrypt_if;
  logic         start;
  logic [127:0] c;
  logic [63:0]  p;
  logic [63:0]  q;
  logic [63:0]  dp;
  logic [63:0]  dq;
  logic [63:0]  qinv;
  logic [127:0] m;
  logic         ready;
  logic         busy;
  logic [2:0]   dbg_state;

  // Handshake: start is accepted only while busy=0 (idle or done); all operands are
  // captured on that edge. ready=1 marks m valid and stays high until the next
  // accepted start or reset. start seen while busy=1 is dropped, never queued.
  modport master (
    output start, c, p, q, dp, dq, qinv,
    input  m, ready, busy, dbg_state
  );

  modport slave (
    input  start, c, p, q, dp, dq, qinv,
    output m, ready, busy, dbg_state
  );
endinterface

// File: rtl/crt_decrypt.sv
// Constant-time RSA-CRT decryption: m = c^d mod p*q from (p, q, dp, dq, qinv).
// Phases: reduce c mod p/q, two parallel exponentiations, Garner recombination.
module crt_decrypt (
  input logic          clk,
  input logic          reset,
  crt_decrypt_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REDUCE = 3'd1,
    S_EXP    = 3'd2,
    S_DIFF   = 3'd3,
    S_HMUL   = 3'd4,
    S_QMUL   = 3'd5,
    S_DONE   = 3'd6
  } state_e;

  state_e       state_q, state_d;
  logic [6:0]   cnt_q, cnt_d;
  logic [5:0]   iter_q, iter_d;
  logic [127:0] work_q, work_d;
  logic [63:0]  p_q, p_d, q_q, q_d, qinv_q, qinv_d;
  logic [63:0]  ep_q, ep_d, eq_q, eq_d;
  logic [63:0]  ap_q, ap_d, aq_q, aq_d;
  logic [63:0]  bp_q, bp_d, bq_q, bq_d;
  logic [63:0]  tpp_q, tpp_d, tsp_q, tsp_d;
  logic [63:0]  tpq_q, tpq_d, tsq_q, tsq_d;
  logic [63:0]  t_q, t_d;
  logic [127:0] m_q, m_d;

  logic [5:0]   idx;
  logic [127:0] qacc;

  // r <- (2r + bit) mod n with one conditional subtract; r < n keeps 2r+bit < 2n.
  function automatic logic [63:0] red_step(input logic [63:0] r, input logic b,
                                           input logic [63:0] n);
    logic [65:0] s;
    s = {1'b0, r, b};
    if (s >= {2'b00, n}) s = s - {2'b00, n};
    return s[63:0];
  endfunction

  // One interleaved modular-multiply step: t <- (2t mod n + (b ? a : 0)) mod n.
  function automatic logic [63:0] mm_step(input logic [63:0] t, input logic [63:0] a,
                                          input logic b, input logic [63:0] n);
    logic [65:0] s;
    s = {1'b0, t, 1'b0};
    if (s >= {2'b00, n}) s = s - {2'b00, n};
    if (b) s = s + {2'b00, a};
    if (s >= {2'b00, n}) s = s - {2'b00, n};
    return s[63:0];
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    iter_d  = iter_q;
    work_d  = work_q;
    p_d     = p_q;
    q_d     = q_q;
    qinv_d  = qinv_q;
    ep_d    = ep_q;
    eq_d    = eq_q;
    ap_d    = ap_q;
    aq_d    = aq_q;
    bp_d    = bp_q;
    bq_d    = bq_q;
    tpp_d   = tpp_q;
    tsp_d   = tsp_q;
    tpq_d   = tpq_q;
    tsq_d   = tsq_q;
    t_d     = t_q;
    m_d     = m_q;
    idx     = ~cnt_q[5:0];
    qacc    = '0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_REDUCE;
          cnt_d   = '0;
          work_d  = bus.c;
          p_d     = bus.p;
          q_d     = bus.q;
          qinv_d  = bus.qinv;
          ep_d    = bus.dp;
          eq_d    = bus.dq;
          ap_d    = 64'd1;
          aq_d    = 64'd1;
          bp_d    = '0;
          bq_d    = '0;
          m_d     = '0;
        end
      end

      // bp/bq act as the running remainders; they become the exponentiation bases.
      S_REDUCE: begin
        bp_d   = red_step(bp_q, work_q[127], p_q);
        bq_d   = red_step(bq_q, work_q[127], q_q);
        work_d = {work_q[126:0], 1'b0};
        cnt_d  = cnt_q + 7'd1;
        if (cnt_q == 7'd127) begin
          state_d = S_EXP;
          cnt_d   = '0;
          iter_d  = '0;
          tpp_d   = '0;
          tsp_d   = '0;
          tpq_d   = '0;
          tsq_d   = '0;
        end
      end

      S_EXP: begin
        if (cnt_q == 7'd64) begin
          bp_d   = tsp_q;
          bq_d   = tsq_q;
          if (ep_q[0]) ap_d = tpp_q;
          if (eq_q[0]) aq_d = tpq_q;
          ep_d   = {1'b0, ep_q[63:1]};
          eq_d   = {1'b0, eq_q[63:1]};
          tpp_d  = '0;
          tsp_d  = '0;
          tpq_d  = '0;
          tsq_d  = '0;
          cnt_d  = '0;
          iter_d = iter_q + 6'd1;
          if (iter_q == 6'd63) state_d = S_DIFF;
        end else begin
          tpp_d = mm_step(tpp_q, bp_q, ap_q[idx], p_q);
          tsp_d = mm_step(tsp_q, bp_q, bp_q[idx], p_q);
          tpq_d = mm_step(tpq_q, bq_q, aq_q[idx], q_q);
          tsq_d = mm_step(tsq_q, bq_q, bq_q[idx], q_q);
          cnt_d = cnt_q + 7'd1;
        end
      end

      // (m1 - m2) mod p; the wrapped branch is exact in 64 bits because the result is < p.
      S_DIFF: begin
        if (ap_q >= aq_q) t_d = ap_q - aq_q;
        else              t_d = ap_q + p_q - aq_q;
        tpp_d   = '0;
        cnt_d   = '0;
        state_d = S_HMUL;
      end

      S_HMUL: begin
        tpp_d = mm_step(tpp_q, qinv_q, t_q[idx], p_q);
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == 7'd63) begin
          state_d = S_QMUL;
          cnt_d   = '0;
          work_d  = '0;
        end
      end

      // work_q is reused as the 128-bit shift-add accumulator for h*q.
      S_QMUL: begin
        qacc   = {work_q[126:0], 1'b0} + (tpp_q[idx] ? {64'd0, q_q} : 128'd0);
        work_d = qacc;
        cnt_d  = cnt_q + 7'd1;
        if (cnt_q == 7'd63) begin
          m_d     = qacc + {64'd0, aq_q};
          state_d = S_DONE;
          cnt_d   = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      iter_q  <= '0;
      work_q  <= '0;
      p_q     <= '0;
      q_q     <= '0;
      qinv_q  <= '0;
      ep_q    <= '0;
      eq_q    <= '0;
      ap_q    <= '0;
      aq_q    <= '0;
      bp_q    <= '0;
      bq_q    <= '0;
      tpp_q   <= '0;
      tsp_q   <= '0;
      tpq_q   <= '0;
      tsq_q   <= '0;
      t_q     <= '0;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      iter_q  <= iter_d;
      work_q  <= work_d;
      p_q     <= p_d;
      q_q     <= q_d;
      qinv_q  <= qinv_d;
      ep_q    <= ep_d;
      eq_q    <= eq_d;
      ap_q    <= ap_d;
      aq_q    <= aq_d;
      bp_q    <= bp_d;
      bq_q    <= bq_d;
      tpp_q   <= tpp_d;
      tsp_q   <= tsp_d;
      tpq_q   <= tpq_d;
      tsq_q   <= tsq_d;
      t_q     <= t_d;
      m_q     <= m_d;
    end
  end

  assign bus.m         = m_q;
  assign bus.ready     = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.dbg_state = state_q;

endmodule

// File: doc/crt_decrypt.md
# crt_decrypt

RSA private-key engine: it recovers m = c^d mod n using the Chinese Remainder Theorem over the 64-bit prime factors p and q. It is the receive-side counterpart of the 128-bit modular exponentiator used for encryption. It sits on the same accelerator datapath and takes the ciphertext that the encrypt path produces. Run time is fixed and independent of data and key bits, for side-channel resistance.

## Interface
- (no parameters; operand widths fixed: 128-bit message/ciphertext, 64-bit key components)
- clk  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-high; returns block to IDLE
- start  in  1  request; sampled only in IDLE or DONE
- c  in  128  ciphertext; any value, c ≥ n allowed
- p  in  64  prime factor; odd, p > q, p > 1
- q  in  64  prime factor; odd, q > 1
- dp  in  64  d mod (p-1)
- dq  in  64  d mod (q-1)
- qinv  in  64  q⁻¹ mod p
- m  out  128  recovered plaintext; valid while ready=1
- ready  out  1  result valid; held until next accepted start or reset
- busy  out  1  operation in progress

## Operation
- All inputs are latched on the cycle start is accepted. Later input changes are ignored until the next accept.
- States and transitions:
  - IDLE → REDUCE on start.
  - REDUCE (128 cyc) → EXP.
  - EXP (64 iterations × 65 cyc) → DIFF.
  - DIFF (1) → HMUL.
  - HMUL (64) → QMUL.
  - QMUL (64) → DONE.
  - DONE → REDUCE on start.
- REDUCE: bit-serial, MSB first over c. Computes cp = c mod p and cq = c mod q in parallel. Per cycle: r ← (2r + bit) mod p, using a single conditional subtract. Intermediate width is 66 bits.
- EXP: two right-to-left square-and-multiply chains run in parallel: (cp, dp, p) and (cq, dq, q).
  - Accumulator starts at 1; base starts at the reduced value.
  - Each iteration runs the product and the square in interleaved bit-serial modular multipliers, 64 cycles, MSB first: acc ← (2·acc mod N + (bit ? a : 0)) mod N.
  - On the 65th cycle: base ← square; accumulator ← product only if the exponent LSB is 1; exponent >> 1.
  - All 64 iterations always execute. There is no early exit on a zero exponent.
- DIFF: t = m1 ≥ m2 ? m1 − m2 : m1 + p − m2 (65-bit intermediate). Because p > q, m2 < p and no extra reduction is needed.
- HMUL: h = qinv · t mod p, using the same interleaved multiplier (64 cyc).
- QMUL: plain 64×64 shift-add product h·q (128 bits). On the final edge, m ← m2 + h·q, which fits in 128 bits since result < n.
- If p ≤ q, p or q even, or qinv is wrong: m is undefined, but latency and the handshake are unchanged.

## Timing
- Reset values: m = 0, ready = 0, busy = 0, state IDLE. Reset wins over start in the same cycle.
- Start sampled high at edge T (IDLE or DONE):
  - busy = 1 and ready = 0 from cycle T+1.
  - REDUCE occupies T+1..T+128.
  - EXP occupies T+129..T+4288.
  - DIFF occupies T+4289.
  - HMUL occupies T+4290..T+4353.
  - QMUL occupies T+4354..T+4417.
  - From T+4418: m valid, ready = 1, busy = 0.
  - Fixed latency is 4418 cycles.
- start while busy is ignored; no queueing.
- start in DONE clears ready and m at the next edge and begins a new operation with the same latency.
- Reset mid-operation aborts immediately: next cycle is IDLE with all outputs at reset values and no partial result.
- start held high continuously: a new operation starts every 4418 cycles, with ready high for exactly one cycle (the DONE cycle) between operations.

## Test plan
- p=11, q=7, dp=3, dq=1, qinv=8, c=47 → m=5 at exactly T+4418. busy high T+1..T+4417.
- Same key, c=62 → m=13 (exercises m1 < m2 wrap in DIFF). c=48 → m=20.
- Same key, c=124 (c ≥ n) → m=5. c=0 → m=0.
- Pulse start again at T+2000 during a run → ignored, result and latency unchanged. Pulse reset at T+3000 → idle next cycle, m=0, ready=0, no ready pulse.
- Back-to-back: start asserted in DONE with c=62 → ready low next cycle, m=13 after a further 4418 cycles.
- 64-bit primes, random messages: compare m against a reference model's pow(c,d,n) for ≥100 vectors, latency constant across all vectors.
